// File: rtl/kdf_pkg.sv
// rtl/kdf_pkg.sv - shared types and helpers for the KDF counter-mode responder
//
// Purpose: holds the responder FSM state encoding, the default domain constant
// that forms the upper half of every counter block, the cipher block width and
// a helper that builds a counter block.
// Ports: none (package).
package kdf_pkg;

  localparam int BLK_W = 128;
  localparam logic [63:0] DOMAIN_DEFAULT = 64'h5049_434E_4943_4B44;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_STORE = 2'd2,
    ST_DONE  = 2'd3
  } kdf_state_t;

  // Plaintext fed to the cipher: fixed domain on top, running counter below.
  function automatic logic [BLK_W-1:0] ctr_block(input logic [63:0] domain,
                                                 input logic [63:0] ctr);
    return {domain, ctr};
  endfunction

endpackage

// File: rtl/kdf_ctr_responder.sv
// rtl/kdf_ctr_responder.sv - KDF start/done responder driving a shared cipher in counter mode
//
// Purpose: on a level-held start, latches the key and encrypts NBLOCKS counter
// blocks {DOMAIN, ctr} through an external cipher port, assembling the
// ciphertexts into deta. done is raised at the end and held until start drops.
// Optional feature: define KDF_TIMEOUT_EN to bound the wait for enc_valid to
// TIMEOUT cycles; a timeout ends the run with err=1 and done=1.
//
// Ports:
//   clk       in   clock
//   reset     in   asynchronous, active-low reset
//   start     in   level request, held until done is seen
//   restart   in   sampled at accept: 0 = counter from 0, 1 = continue counter
//   key       in   128-bit derivation key, latched at accept
//   deta      out  derived output, block i at deta[OUT_W-1-128*i -: 128]
//   done      out  derivation complete, held while start is high
//   enc_req   out  cipher request, held until enc_valid
//   enc_key   out  latched key presented to the cipher
//   enc_in    out  plaintext counter block
//   enc_valid in   one-cycle pulse, enc_out valid
//   enc_out   in   ciphertext
//   err       out  timeout flag (KDF_TIMEOUT_EN builds only)
module kdf_ctr_responder
  import kdf_pkg::*;
#(
  parameter int          NBLOCKS = 8,
  parameter logic [63:0] DOMAIN  = DOMAIN_DEFAULT,
`ifdef KDF_TIMEOUT_EN
  parameter int          TIMEOUT = 255,
`endif
  localparam int         OUT_W   = BLK_W * NBLOCKS
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             restart,
  input  logic [BLK_W-1:0] key,
  output logic [OUT_W-1:0] deta,
  output logic             done,
  output logic             enc_req,
  output logic [BLK_W-1:0] enc_key,
  output logic [BLK_W-1:0] enc_in,
  input  logic             enc_valid,
  input  logic [BLK_W-1:0] enc_out
`ifdef KDF_TIMEOUT_EN
  ,
  output logic             err
`endif
);

  localparam int BLK_IDX_W = (NBLOCKS > 1) ? $clog2(NBLOCKS) : 1;

  kdf_state_t           state, state_next;
  logic [63:0]          ctr;
  logic [63:0]          ctr_start;
  logic [BLK_IDX_W-1:0] blk;
  logic                 last_blk;

  // One-hot-ish action strobes decoded by the FSM and consumed by the datapath.
  logic accept, capture, advance, next_blk, finish, abort, release_done, timeout;

  assign last_blk  = (blk == BLK_IDX_W'(NBLOCKS - 1));
  assign ctr_start = restart ? ctr : 64'd0;

`ifdef KDF_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);
  logic [7:0] wait_cnt;
  logic       timeout_hit;

  // Counts cycles spent in REQ without a response; cleared in every other state
  // so each block gets its own full budget.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_cnt <= 8'd0;
    end else if (state != ST_REQ) begin
      wait_cnt <= 8'd0;
    end else if (!enc_valid) begin
      wait_cnt <= wait_cnt + 8'd1;
    end
  end

  assign timeout_hit = (wait_cnt == TIMEOUT_LAST);
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next   = state;
    accept       = 1'b0;
    capture      = 1'b0;
    advance      = 1'b0;
    next_blk     = 1'b0;
    finish       = 1'b0;
    abort        = 1'b0;
    release_done = 1'b0;
    timeout      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start && !done) begin
          accept     = 1'b1;
          state_next = ST_REQ;
        end
      end
      ST_REQ: begin
        // Abort wins over a same-cycle response so a dropped start never
        // writes another slot.
        if (!start) begin
          abort      = 1'b1;
          state_next = ST_IDLE;
        end else if (enc_valid) begin
          capture    = 1'b1;
          state_next = ST_STORE;
        end
`ifdef KDF_TIMEOUT_EN
        else if (timeout_hit) begin
          timeout    = 1'b1;
          state_next = ST_DONE;
        end
`endif
      end
      ST_STORE: begin
        // The block was consumed, so the counter advances even on abort.
        advance = 1'b1;
        if (!start) begin
          abort      = 1'b1;
          state_next = ST_IDLE;
        end else if (last_blk) begin
          finish     = 1'b1;
          state_next = ST_DONE;
        end else begin
          next_blk   = 1'b1;
          state_next = ST_REQ;
        end
      end
      ST_DONE: begin
        if (!start) begin
          release_done = 1'b1;
          state_next   = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      deta    <= '0;
      done    <= 1'b0;
      enc_req <= 1'b0;
      enc_key <= '0;
      enc_in  <= '0;
      ctr     <= 64'd0;
      blk     <= '0;
    end else begin
      if (accept) begin
        enc_key <= key;
        ctr     <= ctr_start;
        enc_in  <= ctr_block(DOMAIN, ctr_start);
        enc_req <= 1'b1;
        blk     <= '0;
      end
      if (capture) begin
        for (int i = 0; i < NBLOCKS; i++) begin
          if (blk == BLK_IDX_W'(i)) begin
            deta[OUT_W-1-BLK_W*i -: BLK_W] <= enc_out;
          end
        end
        enc_req <= 1'b0;
      end
      if (abort || timeout) begin
        enc_req <= 1'b0;
      end
      if (advance) begin
        ctr <= ctr + 64'd1;
      end
      if (next_blk) begin
        blk     <= blk + BLK_IDX_W'(1);
        enc_in  <= ctr_block(DOMAIN, ctr + 64'd1);
        enc_req <= 1'b1;
      end
      if (finish || timeout) begin
        done <= 1'b1;
      end
      if (release_done) begin
        done <= 1'b0;
      end
    end
  end

`ifdef KDF_TIMEOUT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err <= 1'b0;
    end else if (timeout) begin
      err <= 1'b1;
    end else if (release_done) begin
      err <= 1'b0;
    end
  end
`endif

endmodule

// File: doc/kdf_ctr_responder.md
Name: kdf_ctr_responder

Overview:
- Responder side of the KDF start/end handshake used by the seed/salt setup logic.
- Accepts a level-held `start` with `restart` and a 128-bit key. Produces a 1024-bit derived block `deta` by running a shared SM4 encryption core in counter mode through a request/valid port.
- Raises `done` and holds it until the initiator drops `start`.
- Sits between the seed/salt initiator and the SM4 round core.

Parameters:
- NBLOCKS, 8, number of 128-bit cipher blocks per derivation; OUT_W = 128*NBLOCKS.
- DOMAIN, 64'h5049_434E_4943_4B44, constant upper half of every counter block.
- TIMEOUT, 255, max cycles waiting for enc_valid; used only with KDF_TIMEOUT_EN.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- start  in  1  level request; held high by initiator until done seen
- restart  in  1  sampled with start: 0 = counter from 0, 1 = continue counter
- key  in  128  derivation key, latched at accept
- deta  out  OUT_W  derived output; block i at deta[OUT_W-1-128*i -: 128]
- done  out  1  derivation complete, held while start high
- enc_req  out  1  cipher request
- enc_key  out  128  key to cipher (latched key)
- enc_in  out  128  plaintext {DOMAIN, ctr[63:0]}
- enc_valid  in  1  one-cycle pulse, enc_out valid
- enc_out  in  128  ciphertext
- err  out  1  timeout flag (present only with KDF_TIMEOUT_EN)

Behaviour:
- Reset (async, active-low): state=IDLE; deta=0, done=0, enc_req=0, enc_in=0, enc_key=0, ctr=0, blk=0, err=0.
- FSM: IDLE, REQ, STORE, DONE.
- IDLE: when start=1 and done=0:
  - latch key into enc_key;
  - ctr <= restart ? ctr : 0;
  - blk <= 0;
  - go to REQ.
- REQ:
  - enc_req=1, enc_in={DOMAIN,ctr}, both stable until enc_valid.
  - On enc_valid: capture enc_out into deta slot blk, enc_req <= 0, go to STORE.
  - enc_valid seen outside REQ is ignored.
- STORE:
  - ctr <= ctr+1, wrapping mod 2^64.
  - If blk==NBLOCKS-1, go to DONE and set done <= 1.
  - Otherwise blk <= blk+1 and return to REQ.
- DONE: hold done=1 and deta stable while start=1. When start=0: done <= 0, go to IDLE.
- Re-arm: a new derivation requires start low for at least one cycle after done; done cannot be re-raised without it.
- Abort: start=0 in REQ or STORE:
  - enc_req <= 0, go to IDLE, done stays 0.
  - Already written deta slots keep their new values; the rest keep old values.
  - ctr keeps its advanced value.
  - A pending enc_valid that arrives later is ignored.
- Latency per block: cipher latency L, plus 1 cycle for REQ entry, plus 1 for STORE.
  - Total from accept to done = NBLOCKS*(L+2)+1 cycles.
- enc_key and key changes after accept have no effect until the next accept.
- Mid-operation reset: immediate return to reset values; deta is cleared.

Optional Feature:
- Macro: KDF_TIMEOUT_EN.
- With the macro defined:
  - An 8-bit wait counter runs in REQ.
  - If TIMEOUT cycles pass without enc_valid: enc_req <= 0, err <= 1, done <= 1, go to DONE (same release rule as normal completion).
  - err clears together with done.
- Without the macro: no err port, unbounded wait in REQ.

Decomposition:
- Shared package kdf_pkg holds:
  - FSM state enum (IDLE/REQ/STORE/DONE);
  - DOMAIN default constant;
  - block width 128;
  - function forming counter block {DOMAIN,ctr}.
- No sub-module required. The SM4 core stays external via the enc_* port so it can be shared with other Picnic datapaths.

Test Plan:
All scenarios use a bench cipher model with enc_out = enc_in ^ enc_key, latency L=3.
- Basic, 1024-bit result:
  - Stimulus: key=128'h0123456789ABCDEF_FEDCBA9876543210, restart=0, start held.
  - Response: done rises after 8*5+1=41 cycles; deta block i = {DOMAIN,64'd i} ^ key for i=0..7; done stays 1 until start drops, then 0 next cycle.
- Restart continuation: after the first run completes, drop start, then start with restart=1 → block i = {DOMAIN,64'd(8+i)} ^ key.
- Abort:
  - Stimulus: start low during block 3's REQ.
  - Response: enc_req drops next cycle, done never rises, slots 0..2 updated.
  - A late enc_valid is ignored.
  - A following start with restart=1 continues from ctr=3.
- Held start: keep start high 20 cycles after done → deta constant, enc_req stays 0, no second run.
- Async reset mid-block: assert reset low during block 5 → deta=0, done=0, enc_req=0 immediately; next start (restart=0) yields a fresh block 0.
- KDF_TIMEOUT_EN: cipher never answers → after 255 cycles in REQ: err=1, done=1, enc_req=0; both clear when start drops.
